// File: rtl/riscv_lsu.sv
// Load/store unit: turns execute-stage load/store commands into single bus
// transactions with byte-lane steering, load extension, alignment and timeout checks.
module riscv_lsu #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              cmd_dbus_i,
  input  logic              cmd_dbus_store_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       data_mem_i,
  input  logic              dbus_ack_i,
  input  logic [31:0]       dbus_dat_i,
  output logic [ADDR_W-3:0] addr_mem_o,
  output logic [31:0]       dat_mem_o,
  output logic [3:0]        sel_o,
  output logic              mem_we,
  output logic              stb_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [1:0]        err_code_o,
  output logic [31:0]       dat_reg_o
);

  localparam int unsigned WA    = ADDR_W - 2;
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {IDLE, BUS} state_t;

  state_t           state_q, state_d;
  logic [WA-1:0]    addr_d;
  logic [31:0]      dat_d, dat_reg_d;
  logic [3:0]       sel_d;
  logic             we_d, stb_d, done_d, err_d;
  logic [1:0]       code_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       off_q, off_d, size_q, size_d;
  logic             uns_q, uns_d;

  logic        is_word, is_half, misaligned, expired;
  logic [31:0] lane, load_val;

  assign busy_o = (state_q == BUS);

  // Alignment check and load-lane extraction (aligned halves have off_q[0]=0)
  always_comb begin
    is_word    = size_i[1];
    is_half    = (size_i == 2'b01);
    misaligned = (is_half && addr_i[0]) || (is_word && (addr_i[1:0] != 2'b00));
    expired    = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    lane       = dbus_dat_i >> {off_q, 3'b000};
    case (size_q)
      2'b00:   load_val = uns_q ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      2'b01:   load_val = uns_q ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: load_val = dbus_dat_i;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_mem_o;
    dat_d     = dat_mem_o;
    sel_d     = sel_o;
    we_d      = mem_we;
    stb_d     = stb_o;
    done_d    = 1'b0;
    err_d     = 1'b0;
    code_d    = err_code_o;
    dat_reg_d = dat_reg_o;
    cnt_d     = cnt_q;
    off_d     = off_q;
    size_d    = size_q;
    uns_d     = uns_q;
    case (state_q)
      IDLE: begin
        if (valid_i && cmd_dbus_i) begin
          if (misaligned) begin
            done_d = 1'b1;
            err_d  = 1'b1;
            code_d = 2'b01;
          end else begin
            state_d = BUS;
            stb_d   = 1'b1;
            we_d    = cmd_dbus_store_i;
            addr_d  = addr_i[ADDR_W-1:2];
            off_d   = addr_i[1:0];
            size_d  = size_i;
            uns_d   = unsigned_i;
            cnt_d   = '0;
            case (size_i)
              2'b00:   begin sel_d = 4'(4'b0001 << addr_i[1:0]); dat_d = {4{data_mem_i[7:0]}};  end
              2'b01:   begin sel_d = 4'(4'b0011 << addr_i[1:0]); dat_d = {2{data_mem_i[15:0]}}; end
              default: begin sel_d = 4'b1111;                    dat_d = data_mem_i;            end
            endcase
          end
        end
      end
      BUS: begin
        if (dbus_ack_i) begin
          state_d = IDLE;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          done_d  = 1'b1;
          code_d  = 2'b00;
          if (!mem_we) dat_reg_d = load_val;
        end else if (expired) begin
          state_d = IDLE;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          code_d  = 2'b10;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_mem_o <= '0;
      dat_mem_o  <= '0;
      sel_o      <= '0;
      mem_we     <= 1'b0;
      stb_o      <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      err_code_o <= 2'b00;
      dat_reg_o  <= '0;
      cnt_q      <= '0;
      off_q      <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_mem_o <= addr_d;
      dat_mem_o  <= dat_d;
      sel_o      <= sel_d;
      mem_we     <= we_d;
      stb_o      <= stb_d;
      done_o     <= done_d;
      err_o      <= err_d;
      err_code_o <= code_d;
      dat_reg_o  <= dat_reg_d;
      cnt_q      <= cnt_d;
      off_q      <= off_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed self-checking bench for riscv_lsu with TIMEOUT=4.
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rst, valid, cmd_dbus, cmd_store, uns, ack;
  logic [1:0]  size;
  logic [31:0] addr, data_mem, dbus_dat;
  logic [29:0] addr_mem;
  logic [31:0] dat_mem, dat_reg;
  logic [3:0]  sel;
  logic        mem_we, stb, busy, done, err;
  logic [1:0]  err_code;

  int tests  = 0;
  int fails  = 0;
  int hi_cnt = 0;

  riscv_lsu #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .cmd_dbus_i(cmd_dbus),
    .cmd_dbus_store_i(cmd_store), .size_i(size), .unsigned_i(uns),
    .addr_i(addr), .data_mem_i(data_mem), .dbus_ack_i(ack), .dbus_dat_i(dbus_dat),
    .addr_mem_o(addr_mem), .dat_mem_o(dat_mem), .sel_o(sel), .mem_we(mem_we),
    .stb_o(stb), .busy_o(busy), .done_o(done), .err_o(err),
    .err_code_o(err_code), .dat_reg_o(dat_reg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command for a single cycle; returns just after the accepting edge
  task automatic issue(input logic st, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    valid = 1'b1; cmd_dbus = 1'b1; cmd_store = st; size = sz; uns = u;
    addr = a; data_mem = d;
    tick();
    valid = 1'b0; cmd_dbus = 1'b0;
  endtask

  // Ack for one cycle; returns just after the ack edge
  task automatic give_ack(input logic [31:0] d);
    ack = 1'b1; dbus_dat = d;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; cmd_dbus = 1'b0; cmd_store = 1'b0; uns = 1'b0;
    ack = 1'b0; size = 2'b00; addr = '0; data_mem = '0; dbus_dat = '0;
    tick(); tick();
    check("rst_stb", 32'(stb), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_dat_reg", dat_reg, 32'h0);
    check("rst_done", 32'(done), 32'h0);
    rst = 1'b0;
    tick();

    // lbu 0x1003
    issue(1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0);
    check("lbu_stb", 32'(stb), 32'h1);
    check("lbu_busy", 32'(busy), 32'h1);
    check("lbu_sel", 32'(sel), 32'h8);
    check("lbu_we", 32'(mem_we), 32'h0);
    check("lbu_addr", 32'(addr_mem), 32'h0000_0400);
    give_ack(32'h80FF_1234);
    check("lbu_done", 32'(done), 32'h1);
    check("lbu_err", 32'(err), 32'h0);
    check("lbu_stb_off", 32'(stb), 32'h0);
    check("lbu_data", dat_reg, 32'h0000_0080);
    tick();
    check("lbu_done_pulse", 32'(done), 32'h0);

    // lh 0x1002
    issue(1'b0, 2'b01, 1'b0, 32'h0000_1002, 32'h0);
    check("lh_sel", 32'(sel), 32'hC);
    give_ack(32'h80FF_1234);
    check("lh_data", dat_reg, 32'hFFFF_80FF);
    tick();

    // sb 0xA5 at 0x2001, one wait cycle before ack
    issue(1'b1, 2'b00, 1'b0, 32'h0000_2001, 32'h0000_00A5);
    check("sb_dat", dat_mem, 32'hA5A5_A5A5);
    check("sb_sel", 32'(sel), 32'h2);
    check("sb_we", 32'(mem_we), 32'h1);
    tick();
    check("sb_we_hold", 32'(mem_we), 32'h1);
    check("sb_dat_hold", dat_mem, 32'hA5A5_A5A5);
    give_ack(32'h1111_1111);
    check("sb_we_off", 32'(mem_we), 32'h0);
    check("sb_done", 32'(done), 32'h1);
    check("sb_dat_reg_kept", dat_reg, 32'hFFFF_80FF);
    tick();

    // misaligned lw 0x3002
    issue(1'b0, 2'b10, 1'b0, 32'h0000_3002, 32'h0);
    check("mis_stb", 32'(stb), 32'h0);
    check("mis_busy", 32'(busy), 32'h0);
    check("mis_done", 32'(done), 32'h1);
    check("mis_err", 32'(err), 32'h1);
    check("mis_code", 32'(err_code), 32'h1);
    tick();
    check("mis_done_pulse", 32'(done), 32'h0);
    check("mis_code_hold", 32'(err_code), 32'h1);
    check("mis_dat_reg_kept", dat_reg, 32'hFFFF_80FF);

    // timeout with no ack
    issue(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0);
    hi_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (!stb) break;
      hi_cnt++;
      tick();
    end
    check("to_stb_cycles", 32'(hi_cnt), 32'd4);
    check("to_done", 32'(done), 32'h1);
    check("to_err", 32'(err), 32'h1);
    check("to_code", 32'(err_code), 32'h2);
    check("to_dat_reg_kept", dat_reg, 32'hFFFF_80FF);
    tick();

    // ack coinciding with expiry wins
    issue(1'b0, 2'b10, 1'b0, 32'h0000_4004, 32'h0);
    tick(); tick(); tick();
    check("exp_stb_before", 32'(stb), 32'h1);
    give_ack(32'h1234_5678);
    check("exp_done", 32'(done), 32'h1);
    check("exp_err", 32'(err), 32'h0);
    check("exp_code", 32'(err_code), 32'h0);
    check("exp_data", dat_reg, 32'h1234_5678);

    // back-to-back: new lb accepted during the done cycle
    issue(1'b0, 2'b00, 1'b0, 32'h0000_1000, 32'h0);
    check("b2b_stb", 32'(stb), 32'h1);
    check("b2b_sel", 32'(sel), 32'h1);
    give_ack(32'h0000_00F0);
    check("b2b_data", dat_reg, 32'hFFFF_FFF0);
    tick();

    // reset during BUS, then a late ack
    issue(1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rbus_stb", 32'(stb), 32'h0);
    check("rbus_busy", 32'(busy), 32'h0);
    check("rbus_done", 32'(done), 32'h0);
    check("rbus_dat_reg", dat_reg, 32'h0);
    give_ack(32'hDEAD_BEEF);
    check("late_ack_done", 32'(done), 32'h0);
    check("late_ack_dat_reg", dat_reg, 32'h0);
    check("late_ack_stb", 32'(stb), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
